// File: rtl/rr_mux_n.sv
// rtl/rr_mux_n.sv - N-channel round-robin stream mux with registered output
// Optional packet locking when RR_MUX_PKT_LOCK_EN is defined.
module rr_mux_n #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_sel,
    output logic           out_last
);

    localparam logic [SW:0] N_EXT = (SW+1)'(N);

    logic          load;
    logic          gnt_found;
    logic [SW-1:0] gnt_idx;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_inc;
    logic [SW:0]   cand;
    logic [W-1:0]  sel_data;
    logic          sel_last;

`ifdef RR_MUX_PKT_LOCK_EN
    logic          locked;
    logic [SW-1:0] lock_sel;
`endif

    assign load = !out_valid || out_ready;

    // Round-robin search from ptr; an open packet overrides the search.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (SW+1)'(k);
            if (cand >= N_EXT) cand = cand - N_EXT;
            if (!gnt_found && in_valid[cand[SW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[SW-1:0];
            end
        end
`ifdef RR_MUX_PKT_LOCK_EN
        if (locked) begin
            gnt_found = in_valid[lock_sel];
            gnt_idx   = lock_sel;
        end
`endif
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SW'(i)) sel_data = in_data[i*W +: W];
        end
        sel_last = in_last[gnt_idx];
        ptr_inc  = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load && gnt_found) in_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            ptr       <= '0;
`ifdef RR_MUX_PKT_LOCK_EN
            locked    <= 1'b0;
            lock_sel  <= '0;
`endif
        end else if (load) begin
            out_valid <= gnt_found;
            if (gnt_found) begin
                out_data <= sel_data;
                out_last <= sel_last;
                out_sel  <= gnt_idx;
`ifdef RR_MUX_PKT_LOCK_EN
                if (sel_last) begin
                    locked <= 1'b0;
                    ptr    <= ptr_inc;
                end else begin
                    locked   <= 1'b1;
                    lock_sel <= gnt_idx;
                end
`else
                ptr <= ptr_inc;
`endif
            end
        end
    end

endmodule
